// File: rtl/ramen_customer.sv
// Host-side ramen ordering agent: forwards orders to the shop in two beats, tracks
// expected sales per type, and audits the shop's end-of-day totals.
//
// state    | meaning
// IDLE     | ready for a host order
// BEAT1    | ramen type on the shop bus
// BEAT2    | portion on the shop bus
// WAIT_ORD | waiting for the shop's order response (watchdog armed)
// WAIT_TOT | waiting for the shop's day totals (watchdog armed)
// REPORT   | one-cycle day result, then clear the day's tallies
module ramen_customer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ord_valid,
    output logic        ord_ready,
    input  logic [1:0]  ord_type,
    input  logic        ord_portion,
    input  logic        ord_last,
    output logic        in_valid,
    output logic        selling,
    output logic [1:0]  ramen_type,
    output logic        portion,
    input  logic        out_valid_order,
    input  logic        success,
    input  logic        out_valid_tot,
    input  logic [27:0] sold_num,
    input  logic [14:0] total_gain,
    output logic        resp_valid,
    output logic        resp_success,
    output logic [6:0]  fail_cnt,
    output logic        day_done,
    output logic        day_mismatch,
    output logic        err_timeout
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        BEAT1,
        BEAT2,
        WAIT_ORD,
        WAIT_TOT,
        REPORT
    } state_t;

    state_t            state;
    logic              day_open;
    logic [1:0]        cap_type;
    logic              cap_portion;
    logic              cap_last;
    logic [3:0][6:0]   cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic [7:0]        sum_200;
    logic [7:0]        sum_250;
    logic [14:0]       exp_gain;
    logic              tot_mismatch;
    logic              wd_tc;

    // Gain is only ever compared in 15 bits, so the modular product is exact enough.
    always_comb begin
        sum_200  = {1'b0, cnt[0]} + {1'b0, cnt[2]};
        sum_250  = {1'b0, cnt[1]} + {1'b0, cnt[3]};
        exp_gain = 15'(sum_200) * 15'd200 + 15'(sum_250) * 15'd250;
        tot_mismatch = (sold_num[27:21] != cnt[0]) ||
                       (sold_num[20:14] != cnt[1]) ||
                       (sold_num[13:7]  != cnt[2]) ||
                       (sold_num[6:0]   != cnt[3]) ||
                       (total_gain      != exp_gain);
    end

    // Watchdog counts down from TIMEOUT-1; terminal count marks the TIMEOUT-th idle cycle.
    assign wd_tc = (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            day_open     <= 1'b0;
            cap_type     <= 2'd0;
            cap_portion  <= 1'b0;
            cap_last     <= 1'b0;
            cnt          <= '0;
            wd_cnt       <= '0;
            ord_ready    <= 1'b0;
            in_valid     <= 1'b0;
            selling      <= 1'b0;
            ramen_type   <= 2'd0;
            portion      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_success <= 1'b0;
            fail_cnt     <= 7'd0;
            day_done     <= 1'b0;
            day_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            in_valid   <= 1'b0;
            ramen_type <= 2'd0;
            portion    <= 1'b0;
            resp_valid <= 1'b0;
            day_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (ord_ready && ord_valid) begin
                        cap_type    <= ord_type;
                        cap_portion <= ord_portion;
                        cap_last    <= ord_last;
                        day_open    <= 1'b1;
                        selling     <= 1'b1;
                        ord_ready   <= 1'b0;
                        in_valid    <= 1'b1;
                        ramen_type  <= ord_type;
                        state       <= BEAT1;
                    end else begin
                        ord_ready <= 1'b1;
                        selling   <= day_open;
                    end
                end

                BEAT1: begin
                    in_valid <= 1'b1;
                    portion  <= cap_portion;
                    state    <= BEAT2;
                end

                BEAT2: begin
                    wd_cnt <= WD_LOAD;
                    if (cap_last) begin
                        selling <= 1'b0;
                    end
                    state <= WAIT_ORD;
                end

                WAIT_ORD: begin
                    if (out_valid_order) begin
                        resp_valid   <= 1'b1;
                        resp_success <= success;
                        if (success) begin
                            cnt[cap_type] <= cnt[cap_type] + 7'd1;
                        end else if (fail_cnt != 7'd127) begin
                            fail_cnt <= fail_cnt + 7'd1;
                        end
                        if (cap_last) begin
                            wd_cnt <= WD_LOAD;
                            state  <= WAIT_TOT;
                        end else begin
                            ord_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (wd_tc) begin
                        err_timeout <= 1'b1;
                        ord_ready   <= 1'b1;
                        selling     <= day_open;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end

                WAIT_TOT: begin
                    if (out_valid_tot) begin
                        day_done     <= 1'b1;
                        day_mismatch <= tot_mismatch;
                        state        <= REPORT;
                    end else if (wd_tc) begin
                        err_timeout  <= 1'b1;
                        day_done     <= 1'b1;
                        day_mismatch <= 1'b1;
                        state        <= REPORT;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end

                REPORT: begin
                    day_open     <= 1'b0;
                    cnt          <= '0;
                    fail_cnt     <= 7'd0;
                    day_mismatch <= 1'b0;
                    selling      <= 1'b0;
                    ord_ready    <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    ord_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramen_customer.sv
// Self-checking bench for ramen_customer: directed scenarios plus randomized days
// checked against a simple sales-ledger model.
module tb_ramen_customer;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ord_valid = 1'b0;
    logic        ord_ready;
    logic [1:0]  ord_type = 2'd0;
    logic        ord_portion = 1'b0;
    logic        ord_last = 1'b0;
    logic        in_valid;
    logic        selling;
    logic [1:0]  ramen_type;
    logic        portion;
    logic        out_valid_order = 1'b0;
    logic        success = 1'b0;
    logic        out_valid_tot = 1'b0;
    logic [27:0] sold_num = 28'd0;
    logic [14:0] total_gain = 15'd0;
    logic        resp_valid;
    logic        resp_success;
    logic [6:0]  fail_cnt;
    logic        day_done;
    logic        day_mismatch;
    logic        err_timeout;

    ramen_customer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_type(ord_type),
        .ord_portion(ord_portion), .ord_last(ord_last),
        .in_valid(in_valid), .selling(selling), .ramen_type(ramen_type), .portion(portion),
        .out_valid_order(out_valid_order), .success(success),
        .out_valid_tot(out_valid_tot), .sold_num(sold_num), .total_gain(total_gain),
        .resp_valid(resp_valid), .resp_success(resp_success), .fail_cnt(fail_cnt),
        .day_done(day_done), .day_mismatch(day_mismatch), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Ledger model: bowls sold per type this day and failed orders this day.
    int exp_cnt[4];
    int model_fail;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        model_fail = 0;
    endtask

    function automatic int model_gain();
        return ((exp_cnt[0] + exp_cnt[2]) * 200 + (exp_cnt[1] + exp_cnt[3]) * 250) % 32768;
    endfunction

    function automatic logic [27:0] model_sold();
        return {7'(exp_cnt[0]), 7'(exp_cnt[1]), 7'(exp_cnt[2]), 7'(exp_cnt[3])};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        ord_valid = 1'b0;
        out_valid_order = 1'b0;
        out_valid_tot = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        model_reset();
    endtask

    task automatic place_order(input logic [1:0] t, input logic p, input logic last);
        int guard = 0;
        while (ord_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        checks++;
        if (ord_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait ord_ready=%b want 1", ord_ready);
        end
        ord_valid = 1'b1;
        ord_type = t;
        ord_portion = p;
        ord_last = last;
        step();
        ord_valid = 1'b0;
        ord_type = 2'($urandom);
        ord_portion = 1'($urandom);
        ord_last = 1'($urandom);
        checks++;
        if (in_valid !== 1'b1 || ramen_type !== t || portion !== 1'b0 || selling !== 1'b1 || ord_ready !== 1'b0) begin
            errors++;
            $display("FAIL beat1 in_valid=%b type=%0d portion=%b selling=%b ready=%b want 1 %0d 0 1 0",
                     in_valid, ramen_type, portion, selling, ord_ready, t);
        end
        step();
        checks++;
        if (in_valid !== 1'b1 || ramen_type !== 2'd0 || portion !== p || selling !== 1'b1) begin
            errors++;
            $display("FAIL beat2 in_valid=%b type=%0d portion=%b selling=%b want 1 0 %b 1",
                     in_valid, ramen_type, portion, selling, p);
        end
        step();
        checks++;
        if (in_valid !== 1'b0 || selling !== !last || ord_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_ord_entry in_valid=%b selling=%b ready=%b resp_valid=%b want 0 %b 0 0",
                     in_valid, selling, ord_ready, resp_valid, !last);
        end
    endtask

    task automatic respond(input logic [1:0] t, input logic succ, input int delay,
                           input logic last, input logic also_tot);
        for (int i = 0; i < delay; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0 || ord_ready !== 1'b0) begin
                errors++;
                $display("FAIL resp_idle resp_valid=%b ready=%b want 0 0", resp_valid, ord_ready);
            end
        end
        out_valid_order = 1'b1;
        success = succ;
        out_valid_tot = also_tot;
        step();
        out_valid_order = 1'b0;
        out_valid_tot = 1'b0;
        success = 1'($urandom);
        if (succ) exp_cnt[t] = (exp_cnt[t] + 1) % 128;
        else if (model_fail < 127) model_fail++;
        checks++;
        if (resp_valid !== 1'b1 || resp_success !== succ || fail_cnt !== 7'(model_fail) || day_done !== 1'b0) begin
            errors++;
            $display("FAIL response resp_valid=%b resp_success=%b fail_cnt=%0d day_done=%b want 1 %b %0d 0",
                     resp_valid, resp_success, fail_cnt, day_done, succ, model_fail);
        end
        checks++;
        if (ord_ready !== !last || selling !== !last) begin
            errors++;
            $display("FAIL post_response ready=%b selling=%b want %b %b", ord_ready, selling, !last, !last);
        end
    endtask

    task automatic shop_total(input logic [27:0] sn, input logic [14:0] tg, input int delay,
                              input logic exp_mis, input logic also_ord);
        for (int i = 0; i < delay; i++) begin
            step();
            checks++;
            if (day_done !== 1'b0 || selling !== 1'b0) begin
                errors++;
                $display("FAIL tot_idle day_done=%b selling=%b want 0 0", day_done, selling);
            end
        end
        out_valid_tot = 1'b1;
        out_valid_order = also_ord;
        sold_num = sn;
        total_gain = tg;
        step();
        out_valid_tot = 1'b0;
        out_valid_order = 1'b0;
        checks++;
        if (day_done !== 1'b1 || day_mismatch !== exp_mis || resp_valid !== 1'b0 || selling !== 1'b0) begin
            errors++;
            $display("FAIL report day_done=%b mismatch=%b resp_valid=%b selling=%b want 1 %b 0 0",
                     day_done, day_mismatch, resp_valid, selling, exp_mis);
        end
        step();
        model_reset();
        checks++;
        if (day_done !== 1'b0 || ord_ready !== 1'b1 || fail_cnt !== 7'd0 || selling !== 1'b0) begin
            errors++;
            $display("FAIL after_report day_done=%b ready=%b fail_cnt=%0d selling=%b want 0 1 0 0",
                     day_done, ord_ready, fail_cnt, selling);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({ord_ready, in_valid, selling, ramen_type, portion, resp_valid, resp_success,
             fail_cnt, day_done, day_mismatch, err_timeout} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b in_valid=%b selling=%b err=%b fail=%0d want all 0",
                     ord_ready, in_valid, selling, err_timeout, fail_cnt);
        end
        rst_n = 1'b1;
        step();
        model_reset();
        checks++;
        if (ord_ready !== 1'b1 || selling !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b selling=%b want 1 0", ord_ready, selling);
        end
    endtask

    task automatic test_single_order();
        apply_reset();
        place_order(2'd1, 1'b1, 1'b0);
        respond(2'd1, 1'b1, 2, 1'b0, 1'b0);
    endtask

    task automatic test_full_day();
        apply_reset();
        place_order(2'd0, 1'b0, 1'b0);
        respond(2'd0, 1'b1, 1, 1'b0, 1'b0);
        place_order(2'd1, 1'b1, 1'b0);
        respond(2'd1, 1'b1, 0, 1'b0, 1'b0);
        place_order(2'd3, 1'b0, 1'b0);
        respond(2'd3, 1'b1, 4, 1'b0, 1'b0);
        place_order(2'd2, 1'b1, 1'b1);
        respond(2'd2, 1'b1, 3, 1'b1, 1'b0);
        shop_total({7'd1, 7'd1, 7'd1, 7'd1}, 15'd900, 3, 1'b0, 1'b0);
    endtask

    task automatic test_fail_mismatch();
        apply_reset();
        place_order(2'd0, 1'b0, 1'b0);
        respond(2'd0, 1'b0, 1, 1'b0, 1'b0);
        place_order(2'd2, 1'b0, 1'b1);
        respond(2'd2, 1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (fail_cnt !== 7'd1) begin
            errors++;
            $display("FAIL fail_count fail_cnt=%0d want 1", fail_cnt);
        end
        shop_total({7'd0, 7'd0, 7'd1, 7'd0}, 15'd400, 1, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_strobes();
        apply_reset();
        out_valid_order = 1'b1;
        out_valid_tot = 1'b1;
        success = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0 || day_done !== 1'b0 || ord_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_strobe resp_valid=%b day_done=%b ready=%b want 0 0 1",
                         resp_valid, day_done, ord_ready);
            end
        end
        out_valid_order = 1'b0;
        out_valid_tot = 1'b0;
        place_order(2'd3, 1'b1, 1'b1);
        respond(2'd3, 1'b1, 2, 1'b1, 1'b1);
        shop_total({7'd0, 7'd0, 7'd0, 7'd1}, 15'd250, 2, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        apply_reset();
        place_order(2'd3, 1'b0, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) step();
        checks++;
        if (err_timeout !== 1'b0 || ord_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early err=%b ready=%b resp_valid=%b want 0 0 0", err_timeout, ord_ready, resp_valid);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1 || resp_valid !== 1'b0 || ord_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ord err=%b resp_valid=%b ready=%b want 1 0 1", err_timeout, resp_valid, ord_ready);
        end
        place_order(2'd1, 1'b0, 1'b0);
        respond(2'd1, 1'b1, 1, 1'b0, 1'b0);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky err=%b want 1", err_timeout);
        end
        place_order(2'd2, 1'b0, 1'b1);
        respond(2'd2, 1'b1, 0, 1'b1, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) step();
        checks++;
        if (day_done !== 1'b0) begin
            errors++;
            $display("FAIL tot_timeout_early day_done=%b want 0", day_done);
        end
        step();
        checks++;
        if (day_done !== 1'b1 || day_mismatch !== 1'b1 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tot_timeout day_done=%b mismatch=%b err=%b want 1 1 1", day_done, day_mismatch, err_timeout);
        end
        step();
        model_reset();
        checks++;
        if (ord_ready !== 1'b1 || err_timeout !== 1'b1 || fail_cnt !== 7'd0) begin
            errors++;
            $display("FAIL tot_timeout_exit ready=%b err=%b fail=%0d want 1 1 0", ord_ready, err_timeout, fail_cnt);
        end
    endtask

    task automatic test_reset_mid_flow();
        apply_reset();
        place_order(2'd0, 1'b1, 1'b0);
        respond(2'd0, 1'b0, 0, 1'b0, 1'b0);
        place_order(2'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        checks++;
        if (in_valid !== 1'b0 || selling !== 1'b0 || fail_cnt !== 7'd0 || ord_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait in_valid=%b selling=%b fail=%0d ready=%b want 0 0 0 0",
                     in_valid, selling, fail_cnt, ord_ready);
        end
        rst_n = 1'b1;
        out_valid_order = 1'b1;
        success = 1'b1;
        step();
        out_valid_order = 1'b0;
        model_reset();
        checks++;
        if (resp_valid !== 1'b0 || ord_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_strobe resp_valid=%b ready=%b want 0 1", resp_valid, ord_ready);
        end
        ord_valid = 1'b1;
        ord_type = 2'd2;
        ord_last = 1'b0;
        step();
        ord_valid = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (in_valid !== 1'b0 || selling !== 1'b0) begin
            errors++;
            $display("FAIL reset_beat in_valid=%b selling=%b want 0 0", in_valid, selling);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fail_saturate();
        apply_reset();
        for (int i = 0; i < 130; i++) begin
            place_order(2'($urandom), 1'($urandom), 1'b0);
            respond(2'd0, 1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_wrap_day();
        logic [1:0] t;
        apply_reset();
        for (int i = 0; i < 330; i++) begin
            t = (i < 100) ? 2'd0 : (i < 200) ? 2'd2 : 2'd1;
            place_order(t, 1'($urandom), 1'(i == 329));
            respond(t, 1'b1, 0, 1'(i == 329), 1'b0);
        end
        shop_total(model_sold(), 15'(model_gain()), 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_days();
        int n;
        int which;
        logic [1:0] t;
        logic succ;
        logic last;
        logic perturb;
        logic [27:0] sn;
        logic [14:0] tg;
        apply_reset();
        for (int d = 0; d < 10; d++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                t = 2'($urandom_range(0, 3));
                last = 1'(i == n - 1);
                succ = 1'($urandom_range(0, 3) != 0);
                place_order(t, 1'($urandom), last);
                respond(t, succ, $urandom_range(0, 8), last, 1'($urandom));
            end
            sn = model_sold();
            tg = 15'(model_gain());
            perturb = 1'($urandom);
            if (perturb) begin
                which = $urandom_range(0, 4);
                if (which < 4) sn[which*7 +: 7] = sn[which*7 +: 7] + 7'd1;
                else tg = tg + 15'd1;
            end
            shop_total(sn, tg, $urandom_range(0, 8), perturb, 1'($urandom));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_order();
        test_full_day();
        test_fail_mismatch();
        test_ignored_strobes();
        test_reset_mid_flow();
        test_fail_saturate();
        test_wrap_day();
        test_random_days();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramen_customer.md
RAMEN_CUSTOMER -- requirements
Module: ramen_customer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below, clock and reset first.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, active-low, sampled on clk
- ord_valid  in  1  host order request
- ord_ready  out  1  block can accept an order
- ord_type  in  2  0 TONKOTSU, 1 TONKOTSU_SOY, 2 MISO, 3 MISO_SOY
- ord_portion  in  1  0 small, 1 big
- ord_last  in  1  order is the last of the business day
- in_valid  out  1  order beat to shop
- selling  out  1  shop open flag
- ramen_type  out  2  type, driven on beat 1
- portion  out  1  portion, driven on beat 2
- out_valid_order  in  1  shop order response strobe
- success  in  1  shop order accepted
- out_valid_tot  in  1  shop day-total strobe
- sold_num  in  28  {type0,type1,type2,type3}, 7 bits each
- total_gain  in  15  shop day revenue
- resp_valid  out  1  one-cycle pulse per order response
- resp_success  out  1  captured success, valid with resp_valid
- fail_cnt  out  7  failed orders this day, saturates at 127
- day_done  out  1  one-cycle pulse after day total checked
- day_mismatch  out  1  shop totals differ from expected, valid with day_done
- err_timeout  out  1  sticky watchdog error
REQ-002 Parameter TIMEOUT, default 16, SHALL be the response watchdog limit in cycles.

Function
REQ-003 States SHALL be IDLE, BEAT1, BEAT2, WAIT_ORD, WAIT_TOT, REPORT. All outputs are registered.
REQ-004 In IDLE, ord_ready SHALL be 1; ord_valid&&ord_ready in cycle t SHALL capture type, portion and last, and the block SHALL enter BEAT1.
REQ-005 During BEAT1 (cycle t+1), in_valid SHALL be 1 with ramen_type=captured type; during BEAT2 (cycle t+2), in_valid SHALL be 1 with portion=captured portion; otherwise ramen_type and portion SHALL be 0.
REQ-006 in_valid SHALL be 0 from t+3, when the block is in WAIT_ORD; ord_ready SHALL be 0 in every state except IDLE.
REQ-007 A day_open flag SHALL be set on the first accepted order and cleared in REPORT; selling SHALL be 1 while day_open=1, except as stated in REQ-008.
REQ-008 For a captured last order, selling SHALL be 0 from WAIT_ORD entry through WAIT_TOT and REPORT; selling SHALL never be 0 during BEAT1 or BEAT2.
REQ-009 In WAIT_ORD, out_valid_order SHALL cause one of the following:
- a resp_valid pulse in the next cycle, with resp_success=success;
- if success=1, expected count[type] += 1, wrapping modulo 128;
- if success=0, fail_cnt += 1.
The next state SHALL be WAIT_TOT if last=1, else IDLE.
REQ-010 A watchdog counter SHALL clear on entry to WAIT_ORD and WAIT_TOT and increment each cycle spent there. On reaching TIMEOUT with no strobe, the block SHALL set err_timeout=1, issue no resp_valid, and go to IDLE from WAIT_ORD or to REPORT (with day_mismatch=1) from WAIT_TOT.
REQ-011 In WAIT_TOT, out_valid_tot SHALL trigger a comparison of sold_num fields against the expected counts and of total_gain against expected gain. Expected gain = (cnt0+cnt2)*200 + (cnt1+cnt3)*250, truncated to 15 bits. The next state SHALL be REPORT.
REQ-012 REPORT SHALL last one cycle:
- day_done=1;
- day_mismatch=1 if any compare failed;
- expected counts and fail_cnt cleared at exit;
- next state IDLE.
REQ-013 Strobes arriving in states other than the one that waits for them SHALL be ignored. An out_valid_order and an out_valid_tot in the same cycle SHALL be handled by the current state only.
REQ-014 err_timeout SHALL clear only on reset.

Reset
REQ-015 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear day_open, the captured order, expected counts and the watchdog. All outputs SHALL be 0, including ord_ready, selling and err_timeout.
REQ-016 Reset SHALL take effect in any state, including mid-beat and WAIT_*. in_valid and selling SHALL be 0 in the cycle after the reset edge, and ord_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Verification
REQ-017 Reset: hold rst_n=0 for 2 cycles -> all outputs 0; first cycle after release -> ord_ready=1, selling=0.
REQ-018 Single order: type 1, portion 1 accepted at cycle 0 -> in_valid=1 at cycles 1-2, ramen_type=1 at cycle 1, portion=1 at cycle 2, selling=1; shop returns success=1 -> resp_valid pulse with resp_success=1.
REQ-019 Full day: orders types 0, 1, 3 then last type 2, all succeed -> selling=0 after the last order's beat 2; shop returns sold_num={1,1,1,1} and total_gain=900 -> day_done pulse, day_mismatch=0.
REQ-020 Failure and mismatch: one order type 0 with success=0, then last order type 2 with success=1 -> fail_cnt=1; shop returns sold_num={0,0,1,0} and total_gain=400 -> day_mismatch=1 (expected gain 200).
REQ-021 Timeout: no out_valid_order for 16 cycles -> err_timeout=1, no resp_valid, ord_ready=1 the next cycle; err_timeout stays 1 after a following normal order.
REQ-022 Reset in WAIT_ORD: assert rst_n=0 for one cycle -> in_valid=0, selling=0, fail_cnt=0; a late out_valid_order produces no resp_valid.
